uart_rx: RTL and testbench

- UART receiver. It is the receive-side counterpart of the UART transmit path in the same codebase.
- Oversamples serial line RX_IN at Prescale CLK cycles per bit.
- Recovers start / data / optional parity / stop bits using 3-sample majority vote.
- Delivers parallel byte P_DATA with a one-cycle Data_Valid strobe, plus per-frame parity and stop error pulses.
- Sits between the pad-side RX line and the system register/FIFO logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 15 +
 rtl/uart_rx_sampler.sv | 38 +++
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type constants and the
// three-sample majority helper. The transmit FSM reuses the same encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bus from uart_rx towards register/FIFO logic.
// Data_Valid, Par_Err and Stp_Err are one-cycle strobes with no ready: the
// receiver cannot stall the line, so the consumer must take P_DATA on the
// cycle Data_Valid is high. P_DATA stays stable between valid strobes.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport master (output P_DATA, output Data_Valid, output Par_Err, output Stp_Err);
    modport slave  (input  P_DATA, input  Data_Valid, input  Par_Err, input  Stp_Err);
endinterface

// File: rtl/uart_rx_sampler.sv
// Captures RX at edges P/2-2, P/2-1, P/2 of each bit and presents their
// majority, qualified by sample_valid_o at the decision edge P/2+1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] edge_cnt_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  rx_i,
    output logic                  sampled_bit_o,
    output logic                  sample_valid_o
);

    logic [PRESCALE_W-1:0] half;
    logic [2:0]            samples_q;
    logic [2:0]            samples_d;

    assign half = prescale_i >> 1;

    always_comb begin
        samples_d = samples_q;
        if (edge_cnt_i == half - PRESCALE_W'(2)) samples_d[0] = rx_i;
        if (edge_cnt_i == half - PRESCALE_W'(1)) samples_d[1] = rx_i;
        if (edge_cnt_i == half)                  samples_d[2] = rx_i;
    end

    always_ff @(posedge CLK) begin
        if (!RST) samples_q <= 3'b000;
        else      samples_q <= samples_d;
    end

    assign sampled_bit_o  = majority3(samples_q[0], samples_q[1], samples_q[2]);
    assign sample_valid_o = (edge_cnt_i == half + PRESCALE_W'(1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with registered
// result strobes. Define UART_RX_SYNC_EN to add a 2-flop RX_IN synchronizer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    uart_rx_if.master             rx_out,
    output uart_state_e           dbg_state_o
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    uart_state_e           state_q;
    logic [PRESCALE_W-1:0] edge_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_flag_q;
    logic                  dv_q;
    logic                  pe_q;
    logic                  se_q;
    logic                  rx_s;
    logic                  bit_end;
    logic                  sampled_bit;
    logic                  sample_valid;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge CLK) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], RX_IN};
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .CLK            (CLK),
        .RST            (RST),
        .edge_cnt_i     (edge_q),
        .prescale_i     (prescale_q),
        .rx_i           (rx_s),
        .sampled_bit_o  (sampled_bit),
        .sample_valid_o (sample_valid)
    );

    assign bit_end = (edge_q == prescale_q - PRESCALE_W'(1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            prescale_q <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            if (state_q != IDLE) edge_q <= bit_end ? '0 : edge_q + PRESCALE_W'(1);
            case (state_q)
                IDLE: begin
                    // This cycle is edge 0 of the start bit, so counting resumes at 1.
                    if (!rx_s) begin
                        state_q    <= START;
                        edge_q     <= PRESCALE_W'(1);
                        prescale_q <= Prescale;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        bit_q      <= '0;
                        par_flag_q <= 1'b0;
                    end
                end
                START: begin
                    if (sample_valid && sampled_bit) begin
                        state_q <= IDLE;
                        edge_q  <= '0;
                    end else if (bit_end) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (sample_valid) begin
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        bit_q   <= bit_q + BIT_W'(1);
                    end
                    if (bit_end && bit_q == BIT_W'(DATA_WIDTH))
                        state_q <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (sample_valid)
                        par_flag_q <= sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
                    if (bit_end) state_q <= STOP;
                end
                STOP: begin
                    // Leave at the decision edge so a following start can resync early.
                    if (sample_valid) begin
                        state_q <= IDLE;
                        edge_q  <= '0;
                        se_q    <= !sampled_bit;
                        pe_q    <= par_flag_q;
                        if (sampled_bit && !par_flag_q) begin
                            p_data_q <= shift_q;
                            dv_q     <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_out.P_DATA     = p_data_q;
    assign rx_out.Data_Valid = dv_q;
    assign rx_out.Par_Err    = pe_q;
    assign rx_out.Stp_Err    = se_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a per-cycle line/config/reset script, derives the
// expected strobes from frame-level decoding of that script, then replays it.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int NMAX = 20000;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        CLK = 1'b0;
    logic        RST;
    logic        RX_IN;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic [5:0]  Prescale;
    uart_state_e dbg_state;

    always #5 CLK = ~CLK;

    uart_rx_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .Prescale    (Prescale),
        .rx_out      (rx_if),
        .dbg_state_o (dbg_state)
    );

    // ---------------- stimulus script ----------------
    logic line_a [NMAX];
    logic rst_a  [NMAX];
    int   p_a    [NMAX];
    logic pen_a  [NMAX];
    logic ptyp_a [NMAX];
    int   n = 0;
    int   cur_p = 8;
    logic cur_pen = 1'b0;
    logic cur_pt = 1'b0;
    int   last_t;

    // ---------------- expectations ----------------
    logic       exp_dv [NMAX];
    logic       exp_pe [NMAX];
    logic       exp_se [NMAX];
    logic [7:0] exp_pd [NMAX];
    int         pd_evt [NMAX];
    logic [7:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    // ---------------- driver-side script builders ----------------
    task automatic push(input logic v, input logic r, input int p, input logic pe, input logic pt);
        if (n < NMAX - 2) begin
            line_a[n] = v; rst_a[n] = r; p_a[n] = p; pen_a[n] = pe; ptyp_a[n] = pt;
            n++;
        end
    endtask

    task automatic add_idle(input int k);
        for (int i = 0; i < k; i++) push(1'b1, 1'b1, cur_p, cur_pen, cur_pt);
    endtask

    // cor: edge index whose line value is inverted in every bit (-1 = none).
    task automatic add_frame(input logic [7:0] d, input int p, input logic pen, input logic pt,
                             input logic par_wrong, input logic stop_v, input int cor,
                             input int stop_len, input logic scramble);
        int   nbits;
        int   len;
        logic b;
        logic v;
        nbits = pen ? 11 : 10;
        cur_p = p; cur_pen = pen; cur_pt = pt;
        last_t = n;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)               b = 1'b0;
            else if (i <= 8)          b = d[i-1];
            else if (pen && i == 9)   b = (^d) ^ pt ^ par_wrong;
            else                      b = stop_v;
            len = (i == nbits - 1) ? stop_len : p;
            for (int e = 0; e < len; e++) begin
                v = (e == cor) ? ~b : b;
                if (scramble && !(i == 0 && e == 0))
                    push(v, 1'b1, 2 * $urandom_range(4, 16), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    push(v, 1'b1, cur_p, cur_pen, cur_pt);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic eline(input int c);
`ifdef UART_RX_SYNC_EN
        if (c < 2) return 1'b1;
        if (!rst_a[c-1] || !rst_a[c-2]) return 1'b1;
        return line_a[c-2];
`else
        return line_a[c];
`endif
    endfunction

    function automatic logic maj(input int t, input int b, input int p);
        int base;
        int s;
        base = t + b * p + p / 2 - 2;
        s = 0;
        for (int k = 0; k < 3; k++) s += int'(eline(base + k));
        return s >= 2;
    endfunction

    task automatic run_model();
        int         c, t, p, nb, d, rr;
        logic       pen, pt, glitch, stop_b, par_bad;
        logic [7:0] data;
        logic [7:0] cur;
        for (int i = 0; i < NMAX; i++) begin
            exp_dv[i] = 1'b0; exp_pe[i] = 1'b0; exp_se[i] = 1'b0; pd_evt[i] = -1;
        end
        c = 0;
        while (c < n) begin
            if (!rst_a[c]) begin
                pd_evt[c+1] = 0;
                c++;
            end else if (eline(c) == 1'b0) begin
                t = c; p = p_a[t]; pen = pen_a[t]; pt = ptyp_a[t];
                nb = pen ? 10 : 9;
                glitch = maj(t, 0, p);
                d = glitch ? t + p / 2 + 1 : t + nb * p + p / 2 + 1;
                if (d + 1 >= n) break;
                rr = -1;
                for (int k = t + 1; k <= d; k++) if (!rst_a[k] && rr < 0) rr = k;
                if (rr >= 0) begin
                    c = rr;
                end else if (glitch) begin
                    c = d + 1;
                end else begin
                    for (int k = 0; k < 8; k++) data[k] = maj(t, k + 1, p);
                    par_bad = pen && (maj(t, 9, p) != ((^data) ^ pt));
                    stop_b = maj(t, nb, p);
                    exp_se[d+1] = !stop_b;
                    exp_pe[d+1] = par_bad;
                    if (stop_b && !par_bad) begin
                        exp_dv[d+1] = 1'b1;
                        pd_evt[d+1] = int'(data);
                        exp_q.push_back(data);
                    end
                    c = d + 1;
                end
            end else begin
                c++;
            end
        end
        cur = 8'h00;
        for (int i = 0; i < NMAX; i++) begin
            if (pd_evt[i] >= 0) cur = 8'(pd_evt[i]);
            exp_pd[i] = cur;
        end
    endtask

    // ---------------- replay: driver and compare ----------------
    task automatic drive_all();
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge CLK);
            RX_IN = line_a[c]; RST = rst_a[c];
            Prescale = 6'(p_a[c]); PAR_EN = pen_a[c]; PAR_TYP = ptyp_a[c];
        end
    endtask

    task automatic compare_all();
        int got_words;
        got_words = 0;
        for (int c = 1; c <= n; c++) begin
            @(posedge CLK);
            #1;
            check("data_valid", c, {7'b0, rx_if.Data_Valid}, {7'b0, exp_dv[c]});
            check("par_err",    c, {7'b0, rx_if.Par_Err},    {7'b0, exp_pe[c]});
            check("stp_err",    c, {7'b0, rx_if.Stp_Err},    {7'b0, exp_se[c]});
            check("p_data",     c, rx_if.P_DATA,             exp_pd[c]);
            if (rx_if.Data_Valid === 1'b1 && exp_q.size() > 0) begin
                check("word_order", c, rx_if.P_DATA, exp_q.pop_front());
                got_words++;
            end
        end
        check("words_left", n, 8'(exp_q.size()), 8'd0);
    endtask

    // ---------------- main ----------------
    int t1, t2, t3, t4, t5, t6, t7, t8, tr, tb;
    int p, gap, cor, slen;
    logic pen;

    initial begin
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 8, 1'b0, 1'b0);
        add_idle(10);

        add_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8, 1'b0);  t1 = last_t;
        add_idle(30);
        add_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, 16, 1'b1); t2 = last_t;
        add_idle(30);
        add_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 8, 1'b0);  t3 = last_t;
        add_idle(30);
        add_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8, 1'b0);  t4 = last_t;
        add_idle(30);
        cur_p = 8; cur_pen = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 8, 1'b0, 1'b0);
        add_idle(20);
        add_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8, 1'b0);  t5 = last_t;
        add_idle(30);
        add_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8, 1'b0);   t6 = last_t;
        add_idle(30);
        add_frame(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8, 1'b0);  t7 = last_t;
        tr = t7 + 3 * 8 + 2;
        rst_a[tr] = 1'b0;
        for (int k = tr + 1; k < n; k++) line_a[k] = 1'b1;
        add_idle(30);
        add_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8, 1'b0);  t8 = last_t;
        add_idle(30);
        cur_p = 8; cur_pen = 1'b0; tb = n;
        for (int i = 0; i < 240; i++) push(1'b0, 1'b1, 8, 1'b0, 1'b0);
        add_idle(40);

        for (int f = 0; f < 30; f++) begin
            p    = 2 * $urandom_range(4, 16);
            pen  = 1'($urandom_range(0, 1));
            cor  = ($urandom_range(0, 1) == 1) ? p / 2 - 2 + $urandom_range(0, 2) : -1;
            slen = ($urandom_range(0, 2) == 0) ? p / 2 + 2 : p;
            if ($urandom_range(0, 7) == 0) begin
                cur_p = p;
                for (int i = 0; i < $urandom_range(1, p / 2 - 1); i++) push(1'b0, 1'b1, p, pen, 1'b0);
                add_idle(p);
            end
            add_frame(8'($urandom), p, pen, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 5) == 0, $urandom_range(0, 5) != 0, cor, slen,
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) rst_a[last_t + $urandom_range(1, n - last_t - 1)] = 1'b0;
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
            add_idle(gap);
        end
        add_idle(400);

        run_model();

        // Hand-computed anchors for the model.
        check("pin_a5_dv",     t1 + 78 + LAT, {7'b0, exp_dv[t1 + 78 + LAT]}, 8'd1);
        check("pin_a5_early",  t1 + 77 + LAT, {7'b0, exp_dv[t1 + 77 + LAT]}, 8'd0);
        check("pin_a5_data",   t1 + 78 + LAT, exp_pd[t1 + 78 + LAT], 8'hA5);
        check("pin_3c_pe",     t2 + 170 + LAT, {7'b0, exp_pe[t2 + 170 + LAT]}, 8'd1);
        check("pin_3c_dv",     t2 + 170 + LAT, {7'b0, exp_dv[t2 + 170 + LAT]}, 8'd0);
        check("pin_3c_hold",   t2 + 170 + LAT, exp_pd[t2 + 170 + LAT], 8'hA5);
        check("pin_55_se",     t3 + 78 + LAT, {7'b0, exp_se[t3 + 78 + LAT]}, 8'd1);
        check("pin_0f_data",   t4 + 78 + LAT, exp_pd[t4 + 78 + LAT], 8'h0F);
        check("pin_81_data",   t5 + 78 + LAT, exp_pd[t5 + 78 + LAT], 8'h81);
        check("pin_c3_dv",     t6 + 78 + LAT, {7'b0, exp_dv[t6 + 78 + LAT]}, 8'd1);
        check("pin_c3_data",   t6 + 78 + LAT, exp_pd[t6 + 78 + LAT], 8'hC3);
        check("pin_rst_clear", tr + 1, exp_pd[tr + 1], 8'h00);
        check("pin_7e_data",   t8 + 78 + LAT, exp_pd[t8 + 78 + LAT], 8'h7E);
        check("pin_break_se",  tb + 78 + LAT, {7'b0, exp_se[tb + 78 + LAT]}, 8'd1);

        fork
            drive_all();
            compare_all();
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
